// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the ysyx_24100005 fetch unit.
//   ifu_state_t      : fetch FSM state encoding (FETCH / WAIT / HOLD)
//   DEFAULT_RESET_PC : PC loaded on reset
//   INST_W           : address / instruction width
package ysyx_24100005_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IFU_FETCH = 2'd0,
    IFU_WAIT  = 2'd1,
    IFU_HOLD  = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time to
// instruction memory, holds the returned word for the downstream stage and
// squashes stale fetches on redirect.
// Ports:
//   clk, rst (async, active low)
//   imem_req_valid/ready/addr : fetch request channel
//   imem_rsp_valid/data       : fetch response (valid only, no backpressure)
//   inst_valid/ready, inst, pc: {inst, pc} to decode/execute
//   redirect_valid/pc         : single-cycle PC redirect from downstream
//   misalign_err              : sticky, redirect target not word aligned
//   fetch_cnt                 : instructions delivered
module ysyx_24100005_ifu
  import ysyx_24100005_pkg::*;
#(
  parameter int unsigned       XLEN     = INST_W,
  parameter logic [XLEN-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err,
  output logic [31:0]     fetch_cnt
);

  ifu_state_t      state;
  logic [XLEN-1:0] fpc;
  logic            drop;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  // State already reads FETCH during reset; gating with rst keeps the
  // request low until reset is released.
  assign imem_req_valid = rst && (state == IFU_FETCH);
  assign imem_req_addr  = fpc;
  assign inst_valid     = (state == IFU_HOLD) && !redirect_valid;
  assign inst           = inst_q;
  assign pc             = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IFU_FETCH;
      fpc          <= RESET_PC;
      drop         <= 1'b0;
      inst_q       <= '0;
      pc_q         <= '0;
      misalign_err <= 1'b0;
      fetch_cnt    <= '0;
    end else begin
      if (redirect_valid && (redirect_pc[1:0] != 2'b00))
        misalign_err <= 1'b1;

      case (state)
        IFU_FETCH: begin
          if (redirect_valid)
            fpc <= redirect_tgt;
          if (imem_req_ready) begin
            state <= IFU_WAIT;
            // The request just issued used the old fpc; its data is stale.
            if (redirect_valid)
              drop <= 1'b1;
          end
        end

        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            state <= IFU_FETCH;
            if (redirect_valid) begin
              fpc  <= redirect_tgt;
              drop <= 1'b0;
            end else if (drop) begin
              drop <= 1'b0;
            end else begin
              inst_q <= imem_rsp_data;
              pc_q   <= fpc;
              state  <= IFU_HOLD;
            end
          end else if (redirect_valid) begin
            fpc  <= redirect_tgt;
            drop <= 1'b1;
          end
        end

        IFU_HOLD: begin
          if (redirect_valid) begin
            fpc   <= redirect_tgt;
            state <= IFU_FETCH;
          end else if (inst_ready) begin
            fpc       <= fpc + XLEN'(4);
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= IFU_FETCH;
          end
        end

        default: state <= IFU_FETCH;
      endcase
    end
  end

endmodule

// File: doc/ysyx_24100005_ifu.md
Name: ysyx_24100005_ifu

Overview:
- Instruction fetch unit directly upstream of the core datapath.
- Owns the architectural PC and issues word fetches to instruction memory over a valid/ready request channel with a valid-only response.
- Delivers {inst, pc} to the decode/execute stage over a valid/ready handshake.
- Accepts PC redirects (jal/jalr/branch/trap) from downstream and squashes stale fetches.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, address/instruction width.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, word aligned.
- imem_rsp_valid  in  1  response data valid; only in WAIT, at least 1 cycle after req accept.
- imem_rsp_data  in  XLEN  fetched instruction word.
- inst_valid  out  1  {inst, pc} valid to downstream.
- inst_ready  in  1  downstream consumes.
- inst  out  XLEN  held instruction.
- pc  out  XLEN  address of held instruction.
- redirect_valid  in  1  single-cycle redirect pulse.
- redirect_pc  in  XLEN  new fetch PC.
- misalign_err  out  1  sticky; set when a redirect target has [1:0] != 0.
- fetch_cnt  out  32  count of instructions delivered (inst_valid && inst_ready).

Behaviour:
- States: FETCH, WAIT, HOLD. Registers: fpc, drop, inst_q, pc_q.
- Reset (rst == 0, async):
  - state = FETCH, fpc = RESET_PC, drop = 0, inst_q = 0, pc_q = 0.
  - misalign_err = 0, fetch_cnt = 0.
  - imem_req_valid = 0 while in reset; it goes to 1 in the first cycle after deassertion.
- imem_req_valid = (state == FETCH). imem_req_addr = fpc.
- inst_valid = (state == HOLD) && !redirect_valid. inst = inst_q, pc = pc_q.
- FETCH:
  - Request fires on imem_req_valid && imem_req_ready, then go to WAIT.
  - If redirect_valid is high the same cycle, fpc <= redirect_pc & ~3 and drop <= 1.
  - If redirect_valid is high and the request does not fire, fpc <= redirect_pc & ~3, stay in FETCH, drop unchanged.
- WAIT:
  - On imem_rsp_valid with drop == 1: discard the response, drop <= 0, go to FETCH.
  - On imem_rsp_valid with drop == 0: inst_q <= imem_rsp_data, pc_q <= fpc, go to HOLD.
  - redirect_valid in WAIT: fpc <= redirect_pc & ~3, drop <= 1.
  - Simultaneous rsp and redirect: response discarded, drop <= 0, go to FETCH with the new fpc.
- HOLD:
  - On handshake: fpc <= fpc + 4 (wraps modulo 2^32), go to FETCH, fetch_cnt += 1 (wraps).
  - redirect_valid in HOLD: held instruction squashed (inst_valid masked low that cycle), fpc <= redirect_pc & ~3, go to FETCH. No count increment.
- misalign_err: set on any redirect with redirect_pc[1:0] != 0. Cleared only by reset.
- Latency: minimum 3 cycles per instruction (FETCH→WAIT→HOLD→FETCH) with zero-stall memory. Throughput is not pipelined; one outstanding request maximum.
- Reset asserted mid-WAIT: the in-flight response is the memory model's responsibility to drop. The IFU ignores imem_rsp_valid unless in WAIT.
- imem_rsp_valid outside WAIT is ignored (no state change).

Decomposition:
- Shared package ysyx_24100005_pkg holds:
  - state encoding localparams IFU_FETCH = 2'd0, IFU_WAIT = 2'd1, IFU_HOLD = 2'd2;
  - RESET_PC default;
  - the instruction-width constant.
- Registers use the existing ysyx_24100005_Reg style only if it supports async active-low reset. Otherwise keep them inline.
- No further sub-module; the FSM and datapath stay in one module.

Test Plan:
- Release reset, memory returns 0x00000013 one cycle after each accept, inst_ready = 1 → pcs 0x80000000, 0x80000004, 0x80000008 delivered every 3 cycles; fetch_cnt = 3.
- Hold imem_req_ready = 0 for 4 cycles after reset → imem_req_addr stays 0x80000000, imem_req_valid stays 1, no inst_valid.
- Hold inst_ready = 0 for 5 cycles in HOLD → inst/pc stable, no new request issued, fetch_cnt unchanged.
- Redirect to 0x80000100 during WAIT → pending response discarded, next request addr 0x80000100, delivered pc = 0x80000100.
- Redirect to 0x80000042 during HOLD with inst_ready = 1 → inst_valid low that cycle, next request addr 0x80000040, misalign_err = 1, fetch_cnt not incremented.
- Assert rst low mid-WAIT, then release → state FETCH, imem_req_addr = 0x80000000, all outputs and counters zero, stale imem_rsp_valid ignored.
